prog_cache: RTL and testbench

PROG_CACHE -- requirements
Module: prog_cache

---
 rtl/prog_cache.sv | 140 ++++++++++++++
 tb/tb_prog_cache.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_cache.sv
// Direct-mapped program-word cache between the PC unit and the decode unit.
// The lookup is one cycle deep: PC is registered together with its tag, valid bit and data word.
// A miss fills the whole line, words 0..3 in order, from a handshaked backing store.
// After the fill, one LOOKUP cycle re-reads the arrays so the freshly written line is visible.
module prog_cache #(
    parameter int unsigned TAG_W = 7,
    parameter int unsigned IDX_W = 4,
    parameter int unsigned OFF_W = 2
) (
    input  logic                           clk,
    input  logic                           RST,
    input  logic [TAG_W+IDX_W+OFF_W-1:0]   PC,
    input  logic                           flush,
    output logic [15:0]                    I,
    output logic                           p_cache_miss,
    output logic                           mem_req,
    output logic [TAG_W+IDX_W+OFF_W-1:0]   mem_addr,
    input  logic                           mem_ack,
    input  logic [15:0]                    mem_data
);

    localparam int unsigned AW    = TAG_W + IDX_W + OFF_W;
    localparam int unsigned LW    = AW - OFF_W;
    localparam int unsigned LINES = 1 << IDX_W;
    localparam int unsigned WORDS = 1 << (IDX_W + OFF_W);

    typedef enum logic [1:0] {StIdle, StFill, StLookup} state_e;

    state_e state_q, state_d;

    logic [15:0]      data_mem [WORDS];
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [LINES-1:0] line_valid_q;

    // Registered lookup; only the line part of PC is kept, since the offset is consumed by the read.
    logic [LW-1:0]    pc_q;
    logic [TAG_W-1:0] tag_rd_q;
    logic             valid_rd_q;
    logic [15:0]      data_rd_q;
    logic             look_q;

    // Fill bookkeeping.
    logic [LW-1:0]    base_q;
    logic [OFF_W-1:0] cnt_q;
    logic             flushed_q;

    logic hit;
    logic fill_ack;
    logic fill_last;
    logic start_fill;

    assign hit        = valid_rd_q & (tag_rd_q == pc_q[LW-1 -: TAG_W]);
    assign fill_ack   = (state_q == StFill) & mem_ack;
    assign fill_last  = fill_ack & (cnt_q == '1);
    // pc_q straight out of RST is not a real fetch address, so do not start a fill on it.
    assign start_fill = (state_q == StIdle) & look_q & ~hit;

    // Lookup pipeline: register PC and its valid bit; a flush at this edge masks the read.
    always_ff @(posedge clk) begin
        if (RST) begin
            pc_q       <= '0;
            valid_rd_q <= 1'b0;
            look_q     <= 1'b0;
        end else begin
            pc_q       <= PC[AW-1:OFF_W];
            valid_rd_q <= line_valid_q[PC[OFF_W +: IDX_W]] & ~flush;
            look_q     <= 1'b1;
        end
    end

    // Tag/data arrays: synchronous read at PC, writes from the fill; no reset needed.
    always_ff @(posedge clk) begin
        tag_rd_q  <= tag_mem[PC[OFF_W +: IDX_W]];
        data_rd_q <= data_mem[PC[IDX_W+OFF_W-1:0]];
        if (fill_ack) begin
            data_mem[{base_q[IDX_W-1:0], cnt_q}] <= mem_data;
        end
        if (fill_last) begin
            tag_mem[base_q[IDX_W-1:0]] <= base_q[LW-1 -: TAG_W];
        end
    end

    // Valid bits: flush beats a completing fill, and a fill that saw a flush is left invalid.
    always_ff @(posedge clk) begin
        if (RST || flush) begin
            line_valid_q <= '0;
        end else if (fill_last && !flushed_q) begin
            line_valid_q[base_q[IDX_W-1:0]] <= 1'b1;
        end
    end

    // Fill bookkeeping: latch the line base on a miss, then count the words as they are acked.
    always_ff @(posedge clk) begin
        if (RST) begin
            base_q    <= '0;
            cnt_q     <= '0;
            flushed_q <= 1'b0;
        end else if (start_fill) begin
            base_q    <= pc_q;
            cnt_q     <= '0;
            flushed_q <= 1'b0;
        end else begin
            if (fill_ack) begin
                cnt_q <= cnt_q + OFF_W'(1);
            end
            if ((state_q == StFill) && flush) begin
                flushed_q <= 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start_fill) state_d = StFill;
            StFill:   if (fill_last) state_d = StLookup;
            StLookup: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // FSM outputs: instruction only on an IDLE hit, memory request for the whole fill.
    always_comb begin
        mem_req      = (state_q == StFill);
        mem_addr     = {base_q, cnt_q};
        p_cache_miss = ~hit | (state_q != StIdle);
        I            = (hit && (state_q == StIdle)) ? data_rd_q : 16'h0000;
    end

endmodule

// File: tb/tb_prog_cache.sv
// Directed bench for prog_cache; the backing store returns 16'hA000 + word address.
module tb_prog_cache;

    logic        clk;
    logic        RST;
    logic [12:0] PC;
    logic        flush;
    logic [15:0] I;
    logic        p_cache_miss;
    logic        mem_req;
    logic [12:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_data;

    int total = 0;
    int bad   = 0;
    logic [12:0] got_addr [4];

    prog_cache dut (
        .clk          (clk),
        .RST          (RST),
        .PC           (PC),
        .flush        (flush),
        .I            (I),
        .p_cache_miss (p_cache_miss),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_data     (mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    // Answers nwords fill requests, gap idle cycles before each ack; optional flush on last ack.
    task automatic serve_fill(input int nwords, input int gap, input bit flush_last);
        for (int w = 0; w < 4; w++) got_addr[w] = 13'h1fff;
        for (int w = 0; w < nwords; w++) begin
            int t;
            t = 0;
            while (!mem_req && t < 50) begin
                mem_ack = 1'b0;
                tick();
                t++;
            end
            if (!mem_req) begin
                total++; bad++;
                $display("FAIL fill_timeout word=%0d got mem_req=0 need 1", w);
                mem_ack = 1'b0;
                return;
            end
            for (int g = 0; g < gap; g++) begin
                mem_ack = 1'b0;
                tick();
            end
            got_addr[w] = mem_addr;
            mem_data    = 16'hA000 + 16'(mem_addr);
            mem_ack     = 1'b1;
            if (flush_last && w == nwords - 1) flush = 1'b1;
            tick();
            flush = 1'b0;
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; PC = 13'h0005; flush = 1'b0; mem_ack = 1'b0; mem_data = 16'h0;
        repeat (3) tick();
        RST = 1'b0;
        tick();
        total++;
        if ({p_cache_miss, I, mem_req} !== {1'b1, 16'h0000, 1'b0}) begin
            bad++;
            $display("FAIL reset_state got miss=%b I=%h req=%b need miss=1 I=0000 req=0",
                     p_cache_miss, I, mem_req);
        end
    endtask

    task automatic test_cold_miss();
        serve_fill(4, 1, 1'b0);
        for (int w = 0; w < 4; w++) begin
            total++;
            if (got_addr[w] !== 13'(13'h0004 + w)) begin
                bad++;
                $display("FAIL cold_addr%0d got %h need %h", w, got_addr[w], 13'(13'h0004 + w));
            end
        end
        total++;
        if ({p_cache_miss, mem_req, I} !== {1'b1, 1'b0, 16'h0000}) begin
            bad++;
            $display("FAIL cold_lookup got miss=%b req=%b I=%h need 1 0 0000",
                     p_cache_miss, mem_req, I);
        end
        tick();
        total++;
        if ({p_cache_miss, I} !== {1'b0, 16'hA005}) begin
            bad++;
            $display("FAIL cold_hit got miss=%b I=%h need miss=0 I=a005", p_cache_miss, I);
        end
    endtask

    task automatic test_hit_stream();
        for (int i = 0; i < 4; i++) begin
            PC = 13'(13'h0004 + i);
            tick();
            total++;
            if ({p_cache_miss, mem_req, I} !== {1'b0, 1'b0, 16'(16'hA004 + i)}) begin
                bad++;
                $display("FAIL stream%0d got miss=%b req=%b I=%h need 0 0 %h",
                         i, p_cache_miss, mem_req, I, 16'(16'hA004 + i));
            end
        end
    endtask

    task automatic test_ack_ignored();
        PC = 13'h0006; mem_data = 16'hDEAD; mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        total++;
        if ({p_cache_miss, mem_req, I} !== {1'b0, 1'b0, 16'hA006}) begin
            bad++;
            $display("FAIL stray_ack got miss=%b req=%b I=%h need 0 0 a006",
                     p_cache_miss, mem_req, I);
        end
    endtask

    task automatic test_flush_idle();
        PC = 13'h0005; flush = 1'b1;
        tick();
        flush = 1'b0;
        total++;
        if ({p_cache_miss, I} !== {1'b1, 16'h0000}) begin
            bad++;
            $display("FAIL flush_idle got miss=%b I=%h need miss=1 I=0000", p_cache_miss, I);
        end
        serve_fill(4, 1, 1'b0);
        tick();
        total++;
        if ({p_cache_miss, I} !== {1'b0, 16'hA005}) begin
            bad++;
            $display("FAIL flush_refill got miss=%b I=%h need 0 a005", p_cache_miss, I);
        end
    endtask

    task automatic test_conflict();
        PC = 13'h0045;
        tick();
        total++;
        if (p_cache_miss !== 1'b1) begin
            bad++;
            $display("FAIL conflict_miss got %b need 1", p_cache_miss);
        end
        serve_fill(4, 1, 1'b0);
        for (int w = 0; w < 4; w++) begin
            total++;
            if (got_addr[w] !== 13'(13'h0044 + w)) begin
                bad++;
                $display("FAIL conflict_addr%0d got %h need %h", w, got_addr[w],
                         13'(13'h0044 + w));
            end
        end
        tick();
        total++;
        if ({p_cache_miss, I} !== {1'b0, 16'hA045}) begin
            bad++;
            $display("FAIL conflict_hit got miss=%b I=%h need 0 a045", p_cache_miss, I);
        end
        PC = 13'h0005;
        tick();
        total++;
        if (p_cache_miss !== 1'b1) begin
            bad++;
            $display("FAIL conflict_evict got miss=%b need 1", p_cache_miss);
        end
        serve_fill(4, 1, 1'b0);
        tick();
        total++;
        if ({got_addr[0], p_cache_miss, I} !== {13'h0004, 1'b0, 16'hA005}) begin
            bad++;
            $display("FAIL conflict_refill got addr0=%h miss=%b I=%h need 0004 0 a005",
                     got_addr[0], p_cache_miss, I);
        end
    endtask

    task automatic test_stall();
        int t;
        PC = 13'h0100;
        t = 0;
        while (!mem_req && t < 20) begin
            tick();
            t++;
        end
        for (int c = 0; c < 10; c++) begin
            total++;
            if ({mem_req, mem_addr, p_cache_miss, I} !== {1'b1, 13'h0100, 1'b1, 16'h0000}) begin
                bad++;
                $display("FAIL stall%0d got req=%b addr=%h miss=%b I=%h need 1 0100 1 0000",
                         c, mem_req, mem_addr, p_cache_miss, I);
            end
            tick();
        end
        serve_fill(4, 0, 1'b0);
        tick();
        total++;
        if ({got_addr[3], p_cache_miss, I} !== {13'h0103, 1'b0, 16'hA100}) begin
            bad++;
            $display("FAIL stall_done got addr3=%h miss=%b I=%h need 0103 0 a100",
                     got_addr[3], p_cache_miss, I);
        end
    endtask

    task automatic test_flush_race();
        PC = 13'h0208;
        serve_fill(4, 1, 1'b1);
        total++;
        if ({p_cache_miss, mem_req} !== {1'b1, 1'b0}) begin
            bad++;
            $display("FAIL race_lookup got miss=%b req=%b need 1 0", p_cache_miss, mem_req);
        end
        tick();
        total++;
        if ({p_cache_miss, mem_req, I} !== {1'b1, 1'b0, 16'h0000}) begin
            bad++;
            $display("FAIL race_idle got miss=%b req=%b I=%h need 1 0 0000",
                     p_cache_miss, mem_req, I);
        end
        tick();
        total++;
        if ({mem_req, mem_addr} !== {1'b1, 13'h0208}) begin
            bad++;
            $display("FAIL race_refetch got req=%b addr=%h need 1 0208", mem_req, mem_addr);
        end
        serve_fill(4, 1, 1'b0);
        tick();
        total++;
        if ({p_cache_miss, I} !== {1'b0, 16'hA208}) begin
            bad++;
            $display("FAIL race_hit got miss=%b I=%h need 0 a208", p_cache_miss, I);
        end
    endtask

    task automatic test_back_to_back();
        PC = 13'h030C;
        serve_fill(4, 0, 1'b0);
        for (int w = 0; w < 4; w++) begin
            total++;
            if (got_addr[w] !== 13'(13'h030C + w)) begin
                bad++;
                $display("FAIL b2b_addr%0d got %h need %h", w, got_addr[w], 13'(13'h030C + w));
            end
        end
        tick();
        total++;
        if ({p_cache_miss, I} !== {1'b0, 16'hA30C}) begin
            bad++;
            $display("FAIL b2b_hit got miss=%b I=%h need 0 a30c", p_cache_miss, I);
        end
    endtask

    task automatic test_reset_mid_fill();
        PC = 13'h0310;
        serve_fill(2, 1, 1'b0);
        RST = 1'b1;
        tick();
        total++;
        if (mem_req !== 1'b0) begin
            bad++;
            $display("FAIL midrst_req got %b need 0", mem_req);
        end
        RST = 1'b0;
        tick();
        total++;
        if ({p_cache_miss, I, mem_req} !== {1'b1, 16'h0000, 1'b0}) begin
            bad++;
            $display("FAIL midrst_release got miss=%b I=%h req=%b need 1 0000 0",
                     p_cache_miss, I, mem_req);
        end
        serve_fill(4, 1, 1'b0);
        for (int w = 0; w < 4; w++) begin
            total++;
            if (got_addr[w] !== 13'(13'h0310 + w)) begin
                bad++;
                $display("FAIL midrst_addr%0d got %h need %h", w, got_addr[w],
                         13'(13'h0310 + w));
            end
        end
        tick();
        total++;
        if ({p_cache_miss, I} !== {1'b0, 16'hA310}) begin
            bad++;
            $display("FAIL midrst_hit got miss=%b I=%h need 0 a310", p_cache_miss, I);
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit_stream();
        test_ack_ignored();
        test_flush_idle();
        test_conflict();
        test_stall();
        test_flush_race();
        test_back_to_back();
        test_reset_mid_fill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
